// File: rtl/mesi_snoop_arbiter.sv
// Round-robin owner selection and snoop broadcast/collect sequencer for the shared coherence bus.
// Define SNOOP_TIMEOUT_EN to bound SNOOP residency to TIMEOUT cycles (missing cores read as no-hit).
module mesi_snoop_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CORES-1:0]        req_wr_i,
  input  logic [NUM_CORES-1:0]        snoop_resp_i,
  input  logic [NUM_CORES-1:0]        snoop_done_i,
  output logic [NUM_CORES-1:0]        grant_o,
  output logic [NUM_CORES-1:0]        snoop_req_o,
  output logic [ADDR_W-1:0]           snoop_addr_o,
  output logic                        snoop_inv_o,
  output logic [1:0]                  upd_state_o,
  output logic [NUM_CORES-1:0]        done_o,
  output logic                        busy_o
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_I = 2'b11;

  typedef enum logic [1:0] {IDLE, SNOOP, RESOLVE, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_CORES-1:0] seen_q, seen_d;
  logic                 hit_q, hit_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [NUM_CORES-1:0] sreq_q, sreq_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [1:0]           upd_q, upd_d;
  logic                 busy_q, busy_d;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W:0]       cand;
  logic [NUM_CORES-1:0] pick_oh;
  logic [ADDR_W-1:0]    pick_addr;
  logic                 pick_wr;
  logic                 all_seen;
  logic                 tmo_hit;

  // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
      if (!pick_vld && req_i[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pick_oh   = '0;
    pick_addr = '0;
    pick_wr   = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_oh[k] = 1'b1;
        pick_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        pick_wr    = req_wr_i[k];
      end
    end
  end

`ifdef SNOOP_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == SNOOP) && (tmo_q == 8'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SNOOP) tmo_d = tmo_q + 8'd1;
    if (state_q != SNOOP && state_d == SNOOP) tmo_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    seen_d   = seen_q;
    hit_d    = hit_q;
    grant_d  = grant_q;
    sreq_d   = sreq_q;
    done_d   = '0;
    upd_d    = upd_q;
    all_seen = &(seen_q | snoop_done_i | grant_q);
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SNOOP;
          owner_d = pick_idx;
          wr_d    = pick_wr;
          addr_d  = pick_addr;
          grant_d = pick_oh;
          sreq_d  = ~pick_oh;
        end
      end
      SNOOP: begin
        // Owner's own handshake never counts toward completion or hit.
        seen_d = seen_q | (snoop_done_i & ~grant_q);
        hit_d  = hit_q | (|(snoop_resp_i & snoop_done_i & ~grant_q));
        if (all_seen || tmo_hit) begin
          state_d = RESOLVE;
          sreq_d  = '0;
        end
      end
      RESOLVE: begin
        if (wr_q)       upd_d = MESI_M;
        else if (hit_q) upd_d = MESI_S;
        else            upd_d = MESI_E;
        done_d  = grant_q;
        state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = (owner_q == IDX_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
        seen_d   = '0;
        hit_d    = 1'b0;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      seen_q   <= '0;
      hit_q    <= 1'b0;
      grant_q  <= '0;
      sreq_q   <= '0;
      done_q   <= '0;
      upd_q    <= MESI_I;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      seen_q   <= seen_d;
      hit_q    <= hit_d;
      grant_q  <= grant_d;
      sreq_q   <= sreq_d;
      done_q   <= done_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_o      = grant_q;
  assign snoop_req_o  = sreq_q;
  assign snoop_addr_o = addr_q;
  assign snoop_inv_o  = wr_q;
  assign upd_state_o  = upd_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mesi_snoop_arbiter.sv
// Bench for mesi_snoop_arbiter: table-driven transactions, scoreboarded done/upd_state,
// plus round-robin, reset-abort and stuck-snooper sequences.
module tb_mesi_snoop_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int TMO = 15;
  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_wr, snoop_resp, snoop_done;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  grant, snoop_req, done;
  logic [AW-1:0] snoop_addr;
  logic          snoop_inv, busy;
  logic [1:0]    upd_state;

  logic [3:0] mute, resp_cfg;
  logic       noise;

  always #5 clk = ~clk;

  mesi_snoop_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr), .req_wr_i(req_wr),
    .snoop_resp_i(snoop_resp), .snoop_done_i(snoop_done),
    .grant_o(grant), .snoop_req_o(snoop_req), .snoop_addr_o(snoop_addr),
    .snoop_inv_o(snoop_inv), .upd_state_o(upd_state), .done_o(done), .busy_o(busy)
  );

  // Snooping cores answer as soon as they see snoop_req unless muted; noise adds
  // handshakes from the owner and from everyone while idle, which must be ignored.
  assign snoop_done = (snoop_req & ~mute) | (noise ? (grant | (busy ? 4'h0 : 4'hF)) : 4'h0);
  assign snoop_resp = resp_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [3:0] done; logic [1:0] st; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int              core;
    logic            wr;
    logic [31:0]     addr;
    logic [5:0][3:0] mute;
    logic [5:0][3:0] resp;
    logic            noise;
    logic [1:0]      exp_st;
    int              exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done !== 4'h0) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got %b expected none (t=%0t)", done, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_owner", 32'(done), 32'(e.done));
        check("upd_state", 32'(upd_state), 32'(e.st));
      end
    end
  end

  function automatic vec_t mkv(input int core, input logic wr, input logic [31:0] addr,
                               input logic [3:0] resp, input logic nz, input logic [1:0] st,
                               input int lat);
    vec_t v;
    v.core = core; v.wr = wr; v.addr = addr; v.noise = nz; v.exp_st = st; v.exp_lat = lat;
    for (int i = 0; i < 6; i++) begin
      v.mute[i] = 4'h0;
      v.resp[i] = resp;
    end
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; mute = '0; resp_cfg = '0; noise = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input int budget);
    logic [3:0] oh;
    int cyc, idx;
    bit fin;
    oh = 4'b0001 << v.core;
    req_addr[v.core*AW +: AW] = v.addr;
    req_wr[v.core] = v.wr;
    mute = v.mute[0]; resp_cfg = v.resp[0]; noise = v.noise;
    sb_q.push_back('{done: oh, st: v.exp_st});
    req[v.core] = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < budget) begin
      @(posedge clk);
      cyc++;
      idx = (cyc - 1 > 5) ? 5 : cyc - 1;
      #1;
      mute = v.mute[idx];
      resp_cfg = v.resp[idx];
      @(negedge clk);
      if (cyc == 1) begin
        check("grant", 32'(grant), 32'(oh));
        check("snoop_req", 32'(snoop_req), 32'(~oh & 4'hF));
        check("snoop_inv", 32'(snoop_inv), 32'(v.wr));
        check("busy_active", 32'(busy), 32'd1);
      end
      if (snoop_req !== 4'h0) check("snoop_addr", snoop_addr, v.addr);
      if (done !== 4'h0) begin
        check("latency", 32'(cyc), 32'(v.exp_lat));
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: got no done in %0d cycles expected done for core %0d", budget, v.core);
    end
    @(posedge clk); #1;
    req[v.core] = 1'b0; noise = 1'b0; mute = '0;
    @(negedge clk);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[9];

  initial begin
    int cyc, last, ndone, bad;
    tbl[0] = mkv(0, 1'b0, 32'h0000_1A40, 4'h0,    1'b0, ST_E, 3);
    tbl[1] = mkv(1, 1'b0, 32'h2000_0B80, 4'b0100, 1'b0, ST_S, 3);
    tbl[2] = mkv(3, 1'b1, 32'hDEAD_BEE0, 4'hF,    1'b0, ST_M, 3);
    tbl[3] = mkv(2, 1'b0, 32'h0000_7700, 4'b0100, 1'b1, ST_E, 4);
    tbl[3].mute[0] = 4'b1000;
    tbl[4] = mkv(0, 1'b1, 32'h0000_0040, 4'h0,    1'b0, ST_M, 3);
    tbl[5] = mkv(1, 1'b0, 32'h1234_5678, 4'h0,    1'b0, ST_E, 6);
    for (int i = 0; i < 3; i++) begin
      tbl[5].mute[i] = 4'b0100;
      tbl[5].resp[i] = 4'b0100;
    end
    tbl[6] = mkv(3, 1'b0, 32'hCAFE_0100, 4'h0,    1'b0, ST_S, 4);
    tbl[6].mute[0] = 4'b0100;
    tbl[6].resp[0] = 4'b0010;
    tbl[7] = mkv(0, 1'b0, 32'h0BAD_F00D, 4'h0,    1'b0, ST_E, 5);
    tbl[7].mute[0] = 4'b0100;
    tbl[7].mute[1] = 4'b1110;
    tbl[7].mute[2] = 4'b1011;
    tbl[8] = mkv(1, 1'b1, 32'hFFFF_FFC0, 4'b1001, 1'b0, ST_M, 3);

    rst = 1'b1; req = '0; req_wr = '0; mute = '0; resp_cfg = '0; noise = 1'b0;
    req_addr = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_snoop_req", 32'(snoop_req), 32'd0);
    check("rst_snoop_addr", snoop_addr, 32'd0);
    check("rst_snoop_inv", 32'(snoop_inv), 32'd0);
    check("rst_upd_state", 32'(upd_state), 32'(ST_I));
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(tbl[i], 40);

    // All four requesting continuously: owners 0,1,2,3,0 with a done every 4 cycles.
    do_reset();
    req_wr = '0; mute = '0; resp_cfg = '0;
    for (int k = 0; k < 5; k++) sb_q.push_back('{done: 4'b0001 << (k % 4), st: ST_E});
    req = 4'hF;
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 5 && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done !== 4'h0) begin
        if (ndone == 0) check("rr_first_latency", 32'(cyc), 32'd3);
        else            check("rr_spacing", 32'(cyc - last), 32'd4);
        last = cyc;
        ndone++;
      end
    end
    if (ndone < 5) begin
      n_tests++;
      n_fail++;
      $display("FAIL rr_timeout: got %0d dones expected 5", ndone);
    end
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Reset in SNOOP with core1 owning (rr_ptr now 1) and core0 waiting.
    mute = 4'hF;
    req = 4'b0011;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_owner", 32'(grant), 32'b0010);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mute = '0;
    sb_q.push_back('{done: 4'b0001, st: ST_E});
    @(negedge clk);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_snoop_req", 32'(snoop_req), 32'd0);
    check("abort_snoop_addr", snoop_addr, 32'd0);
    check("abort_snoop_inv", 32'(snoop_inv), 32'd0);
    check("abort_upd_state", 32'(upd_state), 32'(ST_I));
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_grant", 32'(grant), 32'b0001);
    req[1] = 1'b0;
    cyc = 1; ndone = 0;
    while (ndone == 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done !== 4'h0) ndone = 1;
    end
    check("post_reset_latency", 32'(cyc), 32'd3);
    @(posedge clk); #1 req = '0;
    @(negedge clk);

    // Core2 never completes its snoop.
`ifdef SNOOP_TIMEOUT_EN
    begin
      vec_t vt;
      vt = mkv(0, 1'b0, 32'h0000_5000, 4'b0100, 1'b0, ST_E, TMO + 2);
      for (int i = 0; i < 6; i++) vt.mute[i] = 4'b0100;
      run_txn(vt, 40);
    end
`else
    req_addr[0 +: AW] = 32'h0000_5000;
    req_wr[0] = 1'b0;
    mute = 4'b0100;
    resp_cfg = 4'b0100;
    req[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i > 0 && (busy !== 1'b1 || done !== 4'h0)) bad++;
    end
    check("stuck_bad_cycles", 32'(bad), 32'd0);
    check("stuck_snoop_req", 32'(snoop_req), 32'b1110);
    do_reset();
    check("stuck_reset_busy", 32'(busy), 32'd0);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesi_snoop_arbiter.md
# mesi_snoop_arbiter

Round-robin arbiter and snoop sequencer for the shared coherence bus between NUM_CORES L1 cache controllers and the CCU. It grants one core's miss or write request at a time and broadcasts a snoop (bs_req) to every other core. It collects their bs_resp and snoop-done handshakes and returns the resulting MESI state for the requester's line. It sits between the per-core cache controllers and the CCU and serialises all coherence traffic.

## Interface
Parameters:
- NUM_CORES, 4, number of L1 cache controllers (1..8)
- ADDR_W, 32, address width
- TIMEOUT, 15, snoop wait limit in cycles (1..255); used only with SNOOP_TIMEOUT_EN

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_CORES  per-core request; level, held until that core's done pulse
- req_addr  in  NUM_CORES*ADDR_W  flattened request addresses; core k at [k*ADDR_W +: ADDR_W]
- req_wr  in  NUM_CORES  1 = write/RFO, 0 = read miss
- snoop_resp  in  NUM_CORES  core holds a valid copy; sampled only while snoop_done is high
- snoop_done  in  NUM_CORES  core finished its snoop lookup; single-cycle or level
- grant  out  NUM_CORES  one-hot current owner, 0 when idle
- snoop_req  out  NUM_CORES  bs_req to every core except the owner
- snoop_addr  out  ADDR_W  latched owner address
- snoop_inv  out  1  snoop is an invalidate (owner is writing)
- upd_state  out  2  MESI for the owner: M=00, E=01, S=10, I=11; valid with done
- done  out  NUM_CORES  one-hot, one-cycle completion pulse to the owner
- busy  out  1  high in every state except IDLE

## Operation
FSM states: IDLE, SNOOP, RESOLVE, DONE. All outputs are registered.

- **IDLE**
  - If any req bit is set, select the first requester at or after rr_ptr, wrapping modulo NUM_CORES.
  - Latch its index, address and req_wr. Move to SNOOP.
  - If no req bit is set, stay in IDLE.
- **SNOOP**
  - grant = one-hot owner. snoop_req = ~grant. snoop_inv = latched wr. snoop_addr = latched addr.
  - Sticky vector seen |= snoop_done & ~grant.
  - Sticky hit |= |(snoop_resp & snoop_done & ~grant).
  - Exit to RESOLVE on the first cycle where (seen | this cycle's snoop_done | grant) is all ones.
  - With NUM_CORES=1 the exit condition is met on the first SNOOP cycle.
- **RESOLVE**
  - Drop snoop_req. Compute the state:
    - wr → M
    - read with hit → S
    - read with no hit → E
  - Load upd_state. Move to DONE.
- **DONE**
  - Pulse done[owner] for one cycle; upd_state remains valid.
  - rr_ptr ← (owner+1) mod NUM_CORES.
  - Clear seen, hit and grant. Move to IDLE.
- A requester that drops req mid-transaction does not abort it; done is still pulsed.
- A req still high in the IDLE cycle after DONE is treated as a new request.
- snoop_done from the owner, or from any core while in IDLE, RESOLVE or DONE, is ignored.

## Timing
- Reset values, applied on any rising edge with rst=1 from any state:
  - grant=0, snoop_req=0, snoop_addr=0, snoop_inv=0, upd_state=2'b11, done=0, busy=0.
  - rr_ptr=0, seen=0, hit=0, state=IDLE.
- Reset asserted mid-transaction abandons it with no done pulse.
- Latency with req sampled high at edge t:
  - grant and snoop_req are valid after edge t+1.
  - If all snoop_done are high in that first SNOOP cycle, RESOLVE follows at t+2 and done pulses after edge t+3.
- Minimum req-to-done latency is 3 cycles. Each extra snoop-wait cycle adds 1.
- Back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests resolve by round-robin only; there is no starvation, with a worst-case wait of NUM_CORES-1 transactions.

## Configuration
- `SNOOP_TIMEOUT_EN` defined:
  - An 8-bit counter clears on SNOOP entry and increments each SNOOP cycle.
  - When it reaches TIMEOUT, missing cores are treated as snoop_resp=0 and the FSM exits to RESOLVE.
  - Maximum SNOOP residency is TIMEOUT cycles.
- Not defined:
  - No counter is built. SNOOP waits indefinitely for every non-owner snoop_done.

## Test plan
- Core0 read, addr 0x0000_1A40, cores 1-3 assert snoop_done=1 with resp=0 in the first SNOOP cycle → snoop_req=4'b1110, snoop_inv=0, done=4'b0001 3 cycles after req, upd_state=E.
- Core1 read, core2 resp=1, all done → upd_state=S, snoop_addr holds core1's address throughout SNOOP.
- Core3 write → snoop_req=4'b0111, snoop_inv=1, upd_state=M even if resp=1.
- All four req held high continuously, snoops complete immediately → grant sequence 0,1,2,3,0, with a done every 4 cycles.
- Core2 never asserts snoop_done:
  - With SNOOP_TIMEOUT_EN and TIMEOUT=15 → exit after 15 SNOOP cycles, read returns E.
  - Without the macro → busy stays high and no done is pulsed for 100 cycles.
- rst pulsed during SNOOP with core1 the owner, core0 req held → all outputs return to reset values next edge, no done, and core0 is granted first after reset.
